bj_round_controller: RTL and testbench
======================================

BJ_ROUND_CONTROLLER -- requirements
Module: bj_round_controller

Interface
REQ-001 Parameter DEALER_STAND, default 17, meaning dealer draws while its effective total is below this value.
REQ-002 Parameter BJ_LIMIT, default 21, meaning bust threshold; a total above it is bust.
REQ-003 CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-004 resetn  in  1  reset; synchronous, active-low.
REQ-005 deal_pressed  in  1  single-cycle debounced pulse, starts a round.
REQ-006 hit_pressed  in  1  single-cycle debounced pulse, player requests a card.
REQ-007 stand_pressed  in  1  single-cycle debounced pulse, player ends turn.
REQ-008 card_req  out  1  request for the next card from the card source.
REQ-009 card_to_dealer  out  1  target hand of the current request; 0 = player, 1 = dealer; valid while card_req=1.
REQ-010 card_valid  in  1  card source presents card_value.
REQ-011 card_value  in  4  rank; 1 = ace, 2..10 = pips, 11..13 = J/Q/K.
REQ-012 player_total  out  5  player effective total.
REQ-013 dealer_total  out  5  dealer effective total.
REQ-014 result  out  2  00 none, 01 player wins, 10 dealer wins, 11 push.
REQ-015 round_done  out  1  high in DONE.

Function
REQ-016 States SHALL be IDLE, DEAL, PLAYER, DEALER, RESOLVE, DONE.
REQ-017 IDLE/DONE + deal_pressed -> DEAL; totals and result SHALL clear on that edge; card_req SHALL rise on the next cycle. Deal is ignored in all other states.
REQ-018 DEAL issues four requests in order player, dealer, player, dealer, tracked by a 2-bit counter, then enters PLAYER.
REQ-019 Handshake: card_req SHALL stay high until card_valid=1 with a legal rank (1..13). The card is accepted on that edge. card_req SHALL be low the following cycle. There is at most one outstanding request.
REQ-020 Ranks 0, 14 and 15 with card_valid=1 SHALL be discarded, and card_req SHALL remain high.
REQ-021 Card worth: ranks 11..13 = 10, rank 1 = 1 plus the ace flag, others = face value. Hard sum is 5 bits and never wraps; maximum 31.
REQ-022 Effective total = hard+10 if the hand holds an ace and hard+10 <= BJ_LIMIT; otherwise hard.
REQ-023 In PLAYER with no request outstanding: stand_pressed -> DEALER; hit_pressed -> request a player card; hit and stand in the same cycle -> stand wins.
REQ-024 Button pulses while card_req=1 SHALL be dropped, not queued.
REQ-025 After a player card is accepted: effective > BJ_LIMIT -> RESOLVE; effective == BJ_LIMIT -> DEALER; otherwise stay in PLAYER.
REQ-026 Entering PLAYER with a total of 21 after the deal SHALL go directly to DEALER.
REQ-027 DEALER: dealer effective < DEALER_STAND -> request a dealer card; otherwise -> RESOLVE. Soft 17 stands.
REQ-028 RESOLVE takes one cycle, then DONE. Result rules:
- player bust -> 10
- else dealer bust -> 01
- else higher total wins
- equal totals -> 11
REQ-029 result SHALL hold in DONE until a new deal or reset.

Reset
REQ-030 resetn=0 at a clock edge, in any state and including mid-request, SHALL force IDLE with:
- card_req=0, card_to_dealer=0
- totals=0, ace flags=0
- result=00, round_done=0
REQ-031 card_valid SHALL be ignored on any edge where resetn=0.

Structure
REQ-032 Package bj_pkg SHALL hold:
- state encoding
- result codes
- rank constants (ACE=1, TEN_VALUE=10)
- total width 5
REQ-033 Sub-module hand_accumulator (clear, add, rank in; hard sum, ace flag, effective total out) SHALL be instantiated twice, once for the player and once for the dealer.

Verification
REQ-034 Deal, cards 10,6,9,10; stand -> dealer 16 draws 5 -> dealer 21, player 19, result=10, round_done=1.
REQ-035 Deal, cards 1,9,13,7 -> player 21 skips PLAYER input, dealer 16 draws 2 -> 18; result=01.
REQ-036 Deal 10,10,6,7; hit, card 8 -> player 24 bust, no dealer draw, result=10.
REQ-037 hit+stand in the same cycle in PLAYER -> no card_req, DEALER entered; hit pulse while card_req=1 -> ignored.
REQ-038 card_valid with rank 0 then rank 14 -> card_req stays high; rank 5 -> accepted, card_req low the next cycle.
REQ-039 resetn low during DEALER with card_req=1 -> next cycle IDLE, card_req=0, totals 0, result 00.

Source files
------------

// File: rtl/bj_round_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bj_pkg
//  Description : Shared types and constants for the blackjack round
//                controller: FSM states, result codes, rank constants and
//                card-worth helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package bj_pkg;

    localparam int TOTAL_W = 5;

    localparam logic [3:0]         ACE       = 4'd1;
    localparam logic [3:0]         RANK_MAX  = 4'd13;
    localparam logic [3:0]         PIP_MAX   = 4'd10;
    localparam logic [TOTAL_W-1:0] TEN_VALUE = 5'd10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEAL    = 3'd1,
        ST_PLAYER  = 3'd2,
        ST_DEALER  = 3'd3,
        ST_RESOLVE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_PLAYER = 2'b01;
    localparam logic [1:0] RES_DEALER = 2'b10;
    localparam logic [1:0] RES_PUSH   = 2'b11;

    // Hard value of a rank: faces count ten, an ace counts one here.
    function automatic logic [TOTAL_W-1:0] card_worth(input logic [3:0] rank);
        if (rank > PIP_MAX) begin
            return TEN_VALUE;
        end
        return {1'b0, rank};
    endfunction

    function automatic logic is_legal_rank(input logic [3:0] rank);
        return (rank >= ACE) && (rank <= RANK_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bj_round_controller_hand_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : hand_accumulator
//  Description : Keeps one hand: saturating hard sum, ace flag and the
//                effective total (one ace promoted to 11 when it fits).
//  Revision    : 1.0  initial release
// ============================================================================
module hand_accumulator
    import bj_pkg::*;
#(
    parameter int BJ_LIMIT = 21
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_clear,
    input  logic               i_add,
    input  logic [3:0]         i_rank,
    output logic [TOTAL_W-1:0] o_hard,
    output logic               o_ace,
    output logic [TOTAL_W-1:0] o_total
);

    localparam logic [TOTAL_W:0] c_limit = (TOTAL_W+1)'(BJ_LIMIT);

    logic [TOTAL_W-1:0] r_hard;
    logic               r_ace;
    logic [TOTAL_W:0]   w_sum;
    logic [TOTAL_W-1:0] w_sum_sat;
    logic [TOTAL_W:0]   w_soft;

    // One bit of headroom so the hard sum can clamp at all-ones instead of wrapping.
    assign w_sum     = {1'b0, r_hard} + {1'b0, card_worth(i_rank)};
    assign w_sum_sat = w_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];
    assign w_soft    = {1'b0, r_hard} + {1'b0, TEN_VALUE};

    assign o_hard  = r_hard;
    assign o_ace   = r_ace;
    assign o_total = (r_ace && (w_soft <= c_limit)) ? w_soft[TOTAL_W-1:0] : r_hard;

    // Accumulate accepted cards; reset and round-start clear both take priority.
    always_ff @(posedge clk) begin
        if (!resetn || i_clear) begin
            r_hard <= '0;
            r_ace  <= 1'b0;
        end else if (i_add) begin
            r_hard <= w_sum_sat;
            if (i_rank == ACE) begin
                r_ace <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bj_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bj_round_controller
//  Description : Sequences one blackjack round: initial deal, player turn,
//                dealer draw-to-stand, result resolution. Cards come from an
//                external source through a req/valid handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module bj_round_controller
    import bj_pkg::*;
#(
    parameter int DEALER_STAND = 17,
    parameter int BJ_LIMIT     = 21
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               deal_pressed,
    input  logic               hit_pressed,
    input  logic               stand_pressed,
    output logic               card_req,
    output logic               card_to_dealer,
    input  logic               card_valid,
    input  logic [3:0]         card_value,
    output logic [TOTAL_W-1:0] player_total,
    output logic [TOTAL_W-1:0] dealer_total,
    output logic [1:0]         result,
    output logic               round_done
);

    localparam logic [TOTAL_W-1:0] c_limit = TOTAL_W'(BJ_LIMIT);
    localparam logic [TOTAL_W-1:0] c_stand = TOTAL_W'(DEALER_STAND);

    state_t             r_state;
    logic [1:0]         r_deal_cnt;
    logic               r_card_req;
    logic               r_to_dealer;
    logic [1:0]         r_result;
    logic               r_round_done;

    logic               w_accept;
    logic               w_start;
    logic [TOTAL_W-1:0] w_p_total;
    logic [TOTAL_W-1:0] w_d_total;
    logic [TOTAL_W-1:0] w_p_hard;
    logic [TOTAL_W-1:0] w_d_hard;
    logic               w_p_ace;
    logic               w_d_ace;
    logic               w_unused_hand;

    assign w_accept = r_card_req && card_valid && is_legal_rank(card_value);
    assign w_start  = deal_pressed && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Hard sums and ace flags are internal detail; only effective totals drive decisions.
    assign w_unused_hand = ^{w_p_hard, w_p_ace, w_d_hard, w_d_ace};

    hand_accumulator #(.BJ_LIMIT(BJ_LIMIT)) u_player_hand (
        .clk     (CLOCK_50),
        .resetn  (resetn),
        .i_clear (w_start),
        .i_add   (w_accept && !r_to_dealer),
        .i_rank  (card_value),
        .o_hard  (w_p_hard),
        .o_ace   (w_p_ace),
        .o_total (w_p_total)
    );

    hand_accumulator #(.BJ_LIMIT(BJ_LIMIT)) u_dealer_hand (
        .clk     (CLOCK_50),
        .resetn  (resetn),
        .i_clear (w_start),
        .i_add   (w_accept && r_to_dealer),
        .i_rank  (card_value),
        .o_hard  (w_d_hard),
        .o_ace   (w_d_ace),
        .o_total (w_d_total)
    );

    assign card_req       = r_card_req;
    assign card_to_dealer = r_to_dealer;
    assign player_total   = w_p_total;
    assign dealer_total   = w_d_total;
    assign result         = r_result;
    assign round_done     = r_round_done;

    // Round sequencer. Totals are examined only while no request is
    // outstanding, i.e. the cycle after a card lands, so the hands are current.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_deal_cnt   <= 2'd0;
            r_card_req   <= 1'b0;
            r_to_dealer  <= 1'b0;
            r_result     <= RES_NONE;
            r_round_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (deal_pressed) begin
                        r_state      <= ST_DEAL;
                        r_deal_cnt   <= 2'd0;
                        r_card_req   <= 1'b1;
                        r_to_dealer  <= 1'b0;
                        r_result     <= RES_NONE;
                        r_round_done <= 1'b0;
                    end
                end
                ST_DEAL: begin
                    if (w_accept) begin
                        r_card_req <= 1'b0;
                        r_deal_cnt <= r_deal_cnt + 2'd1;
                        if (r_deal_cnt == 2'd3) begin
                            r_state <= ST_PLAYER;
                        end
                    end else if (!r_card_req) begin
                        // Even slots go to the player, odd slots to the dealer.
                        r_card_req  <= 1'b1;
                        r_to_dealer <= r_deal_cnt[0];
                    end
                end
                ST_PLAYER: begin
                    if (r_card_req) begin
                        if (w_accept) begin
                            r_card_req <= 1'b0;
                        end
                    end else if (w_p_total > c_limit) begin
                        r_state <= ST_RESOLVE;
                    end else if (w_p_total == c_limit) begin
                        r_state <= ST_DEALER;
                    end else if (stand_pressed) begin
                        r_state <= ST_DEALER;
                    end else if (hit_pressed) begin
                        r_card_req  <= 1'b1;
                        r_to_dealer <= 1'b0;
                    end
                end
                ST_DEALER: begin
                    if (r_card_req) begin
                        if (w_accept) begin
                            r_card_req <= 1'b0;
                        end
                    end else if (w_d_total < c_stand) begin
                        r_card_req  <= 1'b1;
                        r_to_dealer <= 1'b1;
                    end else begin
                        r_state <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    if (w_p_total > c_limit) begin
                        r_result <= RES_DEALER;
                    end else if (w_d_total > c_limit) begin
                        r_result <= RES_PLAYER;
                    end else if (w_p_total > w_d_total) begin
                        r_result <= RES_PLAYER;
                    end else if (w_d_total > w_p_total) begin
                        r_result <= RES_DEALER;
                    end else begin
                        r_result <= RES_PUSH;
                    end
                    r_round_done <= 1'b1;
                    r_state      <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bj_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bj_round_controller
//  Description : Self-checking bench for bj_round_controller. Directed
//                rounds plus randomized rounds, compared against a
//                card-list model of blackjack scoring.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bj_round_controller;

    logic       clk = 1'b0;
    logic       resetn;
    logic       deal_pressed, hit_pressed, stand_pressed;
    logic       card_req, card_to_dealer;
    logic       card_valid;
    logic [3:0] card_value;
    logic [4:0] player_total, dealer_total;
    logic [1:0] result;
    logic       round_done;

    int total = 0;
    int bad   = 0;

    int deck[$];
    int acts[$];
    int ph[$];
    int dh[$];
    bit force_ill;

    always #5 clk = ~clk;

    bj_round_controller #(.DEALER_STAND(17), .BJ_LIMIT(21)) dut (
        .CLOCK_50       (clk),
        .resetn         (resetn),
        .deal_pressed   (deal_pressed),
        .hit_pressed    (hit_pressed),
        .stand_pressed  (stand_pressed),
        .card_req       (card_req),
        .card_to_dealer (card_to_dealer),
        .card_valid     (card_valid),
        .card_value     (card_value),
        .player_total   (player_total),
        .dealer_total   (dealer_total),
        .result         (result),
        .round_done     (round_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Blackjack scoring straight from the card list.
    function automatic int hand_eff(input int h[$]);
        int  s = 0;
        bit  a = 0;
        foreach (h[i]) begin
            s += (h[i] >= 11) ? 10 : h[i];
            if (s > 31) s = 31;
            if (h[i] == 1) a = 1;
        end
        if (a && (s + 10 <= 21)) return s + 10;
        return s;
    endfunction

    function automatic int exp_result(input int p, input int d);
        if (p > 21) return 2;
        if (d > 21) return 1;
        if (p > d)  return 1;
        if (d > p)  return 2;
        return 3;
    endfunction

    function automatic int next_card();
        if (deck.size() > 0) return deck.pop_front();
        return $urandom_range(1, 13);
    endfunction

    // Wait for a request, verify its target, then deliver one card.
    task automatic serve(input bit to_dealer, input int rank, input bit junk);
        int n = 0;
        int dly;
        while (!card_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!card_req) begin
            check("req_timeout", 0, 1);
            return;
        end
        check("req_target", card_to_dealer, to_dealer);
        dly = $urandom_range(0, 2);
        for (int k = 0; k < dly; k++) begin
            if (junk) begin
                hit_pressed   = 1'($urandom_range(0, 1));
                stand_pressed = 1'($urandom_range(0, 1));
                deal_pressed  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            hit_pressed = 0; stand_pressed = 0; deal_pressed = 0;
            check("req_hold_idle", card_req, 1);
        end
        if (force_ill) begin
            card_valid = 1; card_value = 4'd0;
            @(negedge clk);
            check("ill_rank0", card_req, 1);
            card_value = 4'd14;
            @(negedge clk);
            card_valid = 0;
            check("ill_rank14", card_req, 1);
        end else if ($urandom_range(0, 3) == 0) begin
            card_valid = 1;
            card_value = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(14, 15));
            @(negedge clk);
            card_valid = 0;
            check("ill_rank", card_req, 1);
        end
        card_valid = 1; card_value = 4'(rank);
        @(negedge clk);
        card_valid = 0; card_value = 4'd0;
        check("req_drop", card_req, 0);
    endtask

    task automatic run_round(input bit junk);
        int c, act, n, pe, de, er;
        ph.delete(); dh.delete();
        deal_pressed = 1;
        @(negedge clk);
        deal_pressed = 0;
        check("clr_ptot", player_total, 0);
        check("clr_dtot", dealer_total, 0);
        check("clr_res", result, 0);
        check("clr_done", round_done, 0);
        check("deal_req", card_req, 1);
        for (int i = 0; i < 4; i++) begin
            c = next_card();
            serve(i[0], c, junk);
            if (i[0]) dh.push_back(c); else ph.push_back(c);
        end
        while (hand_eff(ph) < 21) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (acts.size() > 0) act = acts.pop_front();
            else begin
                n = $urandom_range(0, 99);
                act = (n < 50) ? 1 : (n < 85) ? 0 : 2;
            end
            if (act != 1) begin
                stand_pressed = 1; hit_pressed = (act == 2);
                @(negedge clk);
                stand_pressed = 0; hit_pressed = 0;
                check("stand_noreq", card_req, 0);
                break;
            end
            hit_pressed = 1;
            @(negedge clk);
            hit_pressed = 0;
            check("hit_req", card_req, 1);
            c = next_card();
            serve(0, c, junk);
            ph.push_back(c);
        end
        if (hand_eff(ph) <= 21) begin
            while (hand_eff(dh) < 17) begin
                c = next_card();
                serve(1, c, junk);
                dh.push_back(c);
            end
        end
        n = 0;
        while (!round_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        pe = hand_eff(ph);
        de = hand_eff(dh);
        er = exp_result(pe, de);
        check("round_done", round_done, 1);
        check("player_total", player_total, pe);
        check("dealer_total", dealer_total, de);
        check("result", result, er);
        check("done_noreq", card_req, 0);
        repeat (3) @(negedge clk);
        check("result_hold", result, er);
        check("done_hold", round_done, 1);
    endtask

    initial begin
        int n;
        resetn = 0; deal_pressed = 0; hit_pressed = 0; stand_pressed = 0;
        card_valid = 0; card_value = 0; force_ill = 0;
        repeat (3) @(negedge clk);
        resetn = 1;
        @(negedge clk);
        check("rst_req", card_req, 0);
        check("rst_tgt", card_to_dealer, 0);
        check("rst_ptot", player_total, 0);
        check("rst_dtot", dealer_total, 0);
        check("rst_res", result, 0);
        check("rst_done", round_done, 0);

        // Stand on 19; dealer 16 draws 5 to 21.
        deck = '{10, 6, 9, 10, 5}; acts = '{0};
        run_round(0);
        check("d1_res", result, 2);
        check("d1_dtot", dealer_total, 21);
        check("d1_ptot", player_total, 19);

        // Player natural 21 skips the player turn; dealer 16 draws 2.
        deck = '{1, 9, 13, 7, 2}; acts.delete();
        run_round(0);
        check("d2_res", result, 1);
        check("d2_dtot", dealer_total, 18);

        // Hit 8 on 16 busts; dealer does not draw.
        deck = '{10, 10, 6, 7, 8}; acts = '{1};
        run_round(0);
        check("d3_res", result, 2);
        check("d3_ptot", player_total, 24);

        // Hit and stand together: stand wins, no card requested.
        deck = '{10, 10, 8, 9}; acts = '{2};
        run_round(1);
        check("d4_res", result, 2);

        // Illegal ranks 0 and 14 are discarded before every card.
        force_ill = 1;
        deck = '{5, 10, 10, 8}; acts = '{0};
        run_round(0);
        force_ill = 0;
        check("d5_ptot", player_total, 15);

        // Reset while the dealer has a request outstanding; the card on that edge is dropped.
        deck.delete(); acts.delete();
        deal_pressed = 1; @(negedge clk); deal_pressed = 0;
        serve(0, 10, 0); serve(1, 6, 0); serve(0, 9, 0); serve(1, 10, 0);
        stand_pressed = 1; @(negedge clk); stand_pressed = 0;
        n = 0;
        while (!card_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("r_dealer_req", card_req, 1);
        check("r_dealer_tgt", card_to_dealer, 1);
        resetn = 0; card_valid = 1; card_value = 4'd5;
        @(negedge clk);
        resetn = 1; card_valid = 0; card_value = 4'd0;
        check("r_req", card_req, 0);
        check("r_tgt", card_to_dealer, 0);
        check("r_ptot", player_total, 0);
        check("r_dtot", dealer_total, 0);
        check("r_res", result, 0);
        check("r_done", round_done, 0);
        @(negedge clk);
        check("r_idle_req", card_req, 0);

        // Randomized rounds with dropped button pulses and illegal ranks.
        for (int r = 0; r < 40; r++) begin
            run_round(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
